// File: rtl/ray_sink_pkg.sv
// Shared types for the ray sink: FIFO entry layout, output FSM states and default widths.
// The FIFO entry is a packed struct sized by the RAY_* widths below; ray_sink's width
// parameters default to these and must stay equal to them.
package ray_sink_pkg;

  localparam int RAY_IDX_W = 32;
  localparam int RAY_DIR_W = 32;
  localparam int RAY_DIM_W = 13;

  typedef struct packed {
    logic [RAY_IDX_W-1:0] idx;
    logic [RAY_DIR_W-1:0] dir_x;
    logic [RAY_DIR_W-1:0] dir_y;
    logic [RAY_DIR_W-1:0] dir_z;
  } ray_entry_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_CONV,
    OUT_DIV,
    OUT_PRESENT
  } sink_state_t;

endpackage

// File: rtl/ray_sink_if.sv
// Downstream ray bus from the sink to the tracer (valid/ready).
// Signals: out_valid/out_ready handshake, out_dir_x/y/z direction, out_pix_x/y pixel, out_last.
// master = ray_sink (drives the ray), slave = tracer (drives out_ready).
interface ray_sink_if
  import ray_sink_pkg::*;
#(
  parameter int DIR_W = RAY_DIR_W,
  parameter int DIM_W = RAY_DIM_W
);
  logic             out_valid;
  logic             out_ready;
  logic [DIR_W-1:0] out_dir_x;
  logic [DIR_W-1:0] out_dir_y;
  logic [DIR_W-1:0] out_dir_z;
  logic [DIM_W-1:0] out_pix_x;
  logic [DIM_W-1:0] out_pix_y;
  logic             out_last;

  modport master (
    output out_valid, out_dir_x, out_dir_y, out_dir_z, out_pix_x, out_pix_y, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_dir_x, out_dir_y, out_dir_z, out_pix_x, out_pix_y, out_last,
    output out_ready
  );
endinterface

// File: rtl/ray_sink_pixel_index_div.sv
// pixel_index_div: restoring divider turning a linear pixel index into row (quot) and column (rem).
// Ports: clk/reset (sync, active-high), start, dividend, divisor in; busy, done (1-cycle pulse), quot, rem out.
// One quotient bit per cycle, IDX_W cycles after start is taken; divisor==0 yields quot=0, rem=0.
module pixel_index_div #(
  parameter int IDX_W = 32,
  parameter int DIM_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] dividend,
  input  logic [DIM_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] quot,
  output logic [DIM_W-1:0] rem
);
  localparam int CNT_W = $clog2(IDX_W + 1);

  // dq starts as the dividend and shifts left, filling with quotient bits from the bottom.
  logic [IDX_W-1:0] dq;
  logic [DIM_W-1:0] part;
  logic [DIM_W-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [DIM_W:0]   trial;
  logic [DIM_W-1:0] part_nxt;
  logic             qbit;

  // The partial remainder is always < divisor, so after subtraction it fits DIM_W bits.
  always_comb begin
    trial    = {part, dq[IDX_W-1]};
    qbit     = 1'b0;
    part_nxt = trial[DIM_W-1:0];
    if (trial >= {1'b0, dvs}) begin
      qbit     = 1'b1;
      part_nxt = DIM_W'(trial - {1'b0, dvs});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      dq   <= '0;
      part <= '0;
      dvs  <= '0;
      quot <= '0;
      rem  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt  <= '0;
        dq   <= dividend;
        part <= '0;
        dvs  <= divisor;
      end else if (busy) begin
        dq   <= {dq[IDX_W-2:0], qbit};
        part <= part_nxt;
        cnt  <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(IDX_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= (dvs == '0) ? '0 : {dq[IDX_W-2:0], qbit};
          rem  <= (dvs == '0) ? '0 : part_nxt;
        end
      end
    end
  end
endmodule

// File: rtl/ray_sink.sv
// ray_sink: captures rays issued by the generator, buffers them and hands them to the tracer
// with pixel coordinates. Ports: clk, reset (sync, active-high), image_width/height, ray_dir_x/y/z,
// loop_index in; ready_internal (generator flow control), overflow (sticky drop) out; ray_out bus.
// Optional: RAY_SINK_STATS_EN adds stat_rays (accepted rays) and stat_drops (dropped rays), saturating.
module ray_sink
  import ray_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = RAY_IDX_W,
  parameter int DIR_W = RAY_DIR_W,
  parameter int DIM_W = RAY_DIM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIM_W-1:0] image_width,
  input  logic [DIM_W-1:0] image_height,
  input  logic [DIR_W-1:0] ray_dir_x,
  input  logic [DIR_W-1:0] ray_dir_y,
  input  logic [DIR_W-1:0] ray_dir_z,
  input  logic [IDX_W-1:0] loop_index,
  output logic             ready_internal,
  output logic             overflow,
`ifdef RAY_SINK_STATS_EN
  output logic [31:0]      stat_rays,
  output logic [15:0]      stat_drops,
`endif
  ray_sink_if.master       ray_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FW    = 2 * DIM_W;
  localparam int CW    = (IDX_W > FW) ? IDX_W : FW;

  ray_entry_t       mem [DEPTH];
  ray_entry_t       head;
  ray_entry_t       cur;
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [IDX_W-1:0] prev_idx, expected_idx;
  logic [FW-1:0]    frame_px;
  logic [DIM_W-1:0] col, row;
  logic             capture, full, push, pop, drop;
  sink_state_t      state;

  logic             div_start, div_done, div_busy_unused, quot_hi_unused;
  logic [IDX_W-1:0] div_quot;
  logic [DIM_W-1:0] div_rem;

  function automatic logic is_last(input logic [IDX_W-1:0] idx, input logic [FW-1:0] px);
    return CW'(idx) == CW'(px) - CW'(1);
  endfunction

  // Full-width frame size so large images never alias the last-pixel / range checks.
  assign frame_px = FW'(image_width) * FW'(image_height);

  // A new ray shows up as loop_index stepping by exactly one; the ray it announces is prev_idx.
  assign capture   = (loop_index == prev_idx + IDX_W'(1)) && (CW'(prev_idx) < CW'(frame_px));
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = (state == OUT_PRESENT) && ray_out.out_ready;
  // The pop frees its slot first, so a capture on a full FIFO is still accepted alongside a pop.
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign head      = mem[rptr];

  // Row never exceeds the image height, so the quotient's upper bits are always zero.
  assign quot_hi_unused = |div_quot[IDX_W-1:DIM_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_idx       <= '0;
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      ready_internal <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      prev_idx <= loop_index;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count_nxt;
      // Margin of two covers the ray the generator may already have in flight.
      ready_internal <= (CNT_W'(DEPTH) - count_nxt) >= CNT_W'(2);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{idx: prev_idx, dir_x: ray_dir_x, dir_y: ray_dir_y, dir_z: ray_dir_z};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= OUT_IDLE;
      cur               <= '0;
      expected_idx      <= '0;
      col               <= '0;
      row               <= '0;
      div_start         <= 1'b0;
      ray_out.out_valid <= 1'b0;
      ray_out.out_dir_x <= '0;
      ray_out.out_dir_y <= '0;
      ray_out.out_dir_z <= '0;
      ray_out.out_pix_x <= '0;
      ray_out.out_pix_y <= '0;
      ray_out.out_last  <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        OUT_IDLE: begin
          if (count != '0) state <= OUT_CONV;
        end
        OUT_CONV: begin
          cur <= head;
          if (head.idx == expected_idx) begin
            // Sequential ray: the running col/row counters already hold its pixel.
            ray_out.out_valid <= 1'b1;
            ray_out.out_dir_x <= head.dir_x;
            ray_out.out_dir_y <= head.dir_y;
            ray_out.out_dir_z <= head.dir_z;
            ray_out.out_pix_x <= col;
            ray_out.out_pix_y <= row;
            ray_out.out_last  <= is_last(head.idx, frame_px);
            state             <= OUT_PRESENT;
          end else begin
            div_start <= 1'b1;
            state     <= OUT_DIV;
          end
        end
        OUT_DIV: begin
          if (div_done) begin
            // Resynchronise the counters so following sequential rays take the fast path.
            col               <= div_rem;
            row               <= div_quot[DIM_W-1:0];
            ray_out.out_valid <= 1'b1;
            ray_out.out_dir_x <= cur.dir_x;
            ray_out.out_dir_y <= cur.dir_y;
            ray_out.out_dir_z <= cur.dir_z;
            ray_out.out_pix_x <= div_rem;
            ray_out.out_pix_y <= div_quot[DIM_W-1:0];
            ray_out.out_last  <= is_last(cur.idx, frame_px);
            state             <= OUT_PRESENT;
          end
        end
        OUT_PRESENT: begin
          if (ray_out.out_ready) begin
            ray_out.out_valid <= 1'b0;
            if (ray_out.out_last) begin
              expected_idx <= '0;
              col          <= '0;
              row          <= '0;
            end else begin
              expected_idx <= cur.idx + IDX_W'(1);
              if (col == image_width - DIM_W'(1)) begin
                col <= '0;
                row <= row + DIM_W'(1);
              end else begin
                col <= col + DIM_W'(1);
              end
            end
            state <= (count_nxt != '0) ? OUT_CONV : OUT_IDLE;
          end
        end
        default: state <= OUT_IDLE;
      endcase
    end
  end

  pixel_index_div #(
    .IDX_W(IDX_W),
    .DIM_W(DIM_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(cur.idx),
    .divisor (image_width),
    .busy    (div_busy_unused),
    .done    (div_done),
    .quot    (div_quot),
    .rem     (div_rem)
  );

`ifdef RAY_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rays  <= '0;
      stat_drops <= '0;
    end else begin
      if (pop && (stat_rays != '1))   stat_rays  <= stat_rays + 32'd1;
      if (drop && (stat_drops != '1)) stat_drops <= stat_drops + 16'd1;
    end
  end
`endif
endmodule
